// File: rtl/div_pkg.sv
// Shared types and sizing helpers for the iterative divider.
package div_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FIN
  } state_e;

  // Number of RUN cycles needed to resolve all quotient bits.
  function automatic int unsigned iter_count(input int unsigned width, input int unsigned steps);
    return width / steps;
  endfunction

  // Counter width large enough to hold the iteration count itself.
  function automatic int unsigned cnt_width(input int unsigned width, input int unsigned steps);
    return $clog2(iter_count(width, steps)) + 1;
  endfunction

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division step: shift in a dividend bit, subtract if it fits.
module div_step #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic [WIDTH-1:0] divisor_i,
  input  logic             bit_i,
  output logic [WIDTH-1:0] rem_c,
  output logic             q_c
);

  // Shifted value needs one extra bit since it can reach 2*divisor-1.
  logic [WIDTH:0] shifted_c;

  // Compare-and-subtract for a single quotient bit.
  always_comb begin
    shifted_c = {rem_i, bit_i};
    q_c       = (shifted_c >= {1'b0, divisor_i});
    rem_c     = q_c ? WIDTH'(shifted_c - {1'b0, divisor_i}) : shifted_c[WIDTH-1:0];
  end

endmodule

// File: rtl/iter_divider.sv
// Multi-cycle restoring divider, STEPS quotient bits per clock, start/busy/done handshake.
// Optional macro DIV_SIGNED_EN adds op_signed for two's-complement operands.
module iter_divider
  import div_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned STEPS = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
`ifdef DIV_SIGNED_EN
  input  logic             op_signed,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int unsigned ITERS = iter_count(WIDTH, STEPS);
  localparam int unsigned CNT_W = cnt_width(WIDTH, STEPS);

  if (WIDTH < 2 || STEPS == 0 || (WIDTH % STEPS) != 0) begin : g_param_err
    $error("iter_divider: WIDTH must be >= 2 and STEPS must divide WIDTH");
  end

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   dvd_q, dvd_d;     // dividend bits, quotient bits shift in from the LSB
  logic [WIDTH-1:0]   dsr_q, dsr_d;     // divisor magnitude
  logic [WIDTH-1:0]   rem_q, rem_d;     // partial remainder, always below divisor
  logic               qneg_q, qneg_d;
  logic               rneg_q, rneg_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [WIDTH-1:0]   quo_q, quo_d;
  logic [WIDTH-1:0]   rmd_q, rmd_d;
  logic               dbz_q, dbz_d;

  logic               sgn_c;
  logic               dvd_neg_c, dsr_neg_c;
  logic [WIDTH-1:0]   dvd_mag_c, dsr_mag_c;
  logic [STEPS-1:0]   chain_q_c;
  logic [WIDTH-1:0]   chain_rem_c;
  logic [WIDTH-1:0]   dvd_shift_c;

`ifdef DIV_SIGNED_EN
  assign sgn_c = op_signed;
`else
  assign sgn_c = 1'b0;
`endif

  // Signed operands are reduced to magnitudes so the datapath stays unsigned.
  assign dvd_neg_c = sgn_c & dividend[WIDTH-1];
  assign dsr_neg_c = sgn_c & divisor[WIDTH-1];
  assign dvd_mag_c = dvd_neg_c ? (~dividend + WIDTH'(1)) : dividend;
  assign dsr_mag_c = dsr_neg_c ? (~divisor + WIDTH'(1)) : divisor;

  // Chain of STEPS restoring steps, MSB of the remaining dividend first.
  for (genvar j = 0; j < STEPS; j++) begin : g_step
    logic [WIDTH-1:0] rem_in;
    logic [WIDTH-1:0] rem_out;
    if (j == 0) begin : g_first
      assign rem_in = rem_q;
    end else begin : g_next
      assign rem_in = g_step[j-1].rem_out;
    end
    div_step #(.WIDTH(WIDTH)) u_div_step (
      .rem_i     (rem_in),
      .divisor_i (dsr_q),
      .bit_i     (dvd_q[WIDTH-1-j]),
      .rem_c     (rem_out),
      .q_c       (chain_q_c[STEPS-1-j])
    );
  end

  assign chain_rem_c = g_step[STEPS-1].rem_out;

  if (STEPS < WIDTH) begin : g_shift
    assign dvd_shift_c = {dvd_q[WIDTH-STEPS-1:0], chain_q_c};
  end else begin : g_whole
    assign dvd_shift_c = WIDTH'(chain_q_c);
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      dvd_q   <= '0;
      dsr_q   <= '0;
      rem_q   <= '0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      quo_q   <= '0;
      rmd_q   <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dvd_q   <= dvd_d;
      dsr_q   <= dsr_d;
      rem_q   <= rem_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      quo_q   <= quo_d;
      rmd_q   <= rmd_d;
      dbz_q   <= dbz_d;
    end
  end

  // Next-state, iteration and result update logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dvd_d   = dvd_q;
    dsr_d   = dsr_q;
    rem_d   = rem_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    done_d  = 1'b0;
    quo_d   = quo_q;
    rmd_d   = rmd_q;
    dbz_d   = dbz_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          cnt_d   = '0;
          rem_d   = '0;
          dvd_d   = dvd_mag_c;
          dsr_d   = dsr_mag_c;
          qneg_d  = dvd_neg_c ^ dsr_neg_c;
          rneg_d  = dvd_neg_c;
          state_d = (divisor == '0) ? FIN : RUN;
        end
      end
      RUN: begin
        rem_d = chain_rem_c;
        dvd_d = dvd_shift_c;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(ITERS - 1)) begin
          state_d = FIN;
        end
      end
      FIN: begin
        done_d  = 1'b1;
        state_d = IDLE;
        if (dsr_q == '0) begin
          // dvd_q still holds the untouched dividend magnitude here.
          quo_d = '1;
          rmd_d = rneg_q ? (~dvd_q + WIDTH'(1)) : dvd_q;
          dbz_d = 1'b1;
        end else begin
          quo_d = qneg_q ? (~dvd_q + WIDTH'(1)) : dvd_q;
          rmd_d = rneg_q ? (~rem_q + WIDTH'(1)) : rem_q;
          dbz_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign quotient    = quo_q;
  assign remainder   = rmd_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_iter_divider.sv
// Self-checking bench: STEPS=1 and STEPS=4 dividers side by side against an arithmetic model.
module tb_iter_divider;

  logic              clk;
  logic              rst_n;
  logic              start;
  logic [31:0]       dividend;
  logic [31:0]       divisor;
`ifdef DIV_SIGNED_EN
  logic              op_sg;
`endif
  logic [1:0]        busy_w, done_w, z_w;
  logic [1:0][31:0]  q_w, r_w;

  int errors = 0;
  int checks = 0;

  // Per-operation observations, index 0 = STEPS=1, index 1 = STEPS=4.
  logic [31:0] e_q, e_r;
  logic        e_z;
  int          e_lat[2];
  logic [31:0] o_q[2], o_r[2], o_hq[2], o_hr[2];
  logic        o_z[2], o_busy_end[2];
  int          o_lat[2], o_dn[2];
  bit          o_bb[2];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  iter_divider #(.WIDTH(32), .STEPS(1)) u_dut1 (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
`ifdef DIV_SIGNED_EN
    .op_signed   (op_sg),
`endif
    .busy        (busy_w[0]),
    .done        (done_w[0]),
    .quotient    (q_w[0]),
    .remainder   (r_w[0]),
    .div_by_zero (z_w[0])
  );

  iter_divider #(.WIDTH(32), .STEPS(4)) u_dut4 (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
`ifdef DIV_SIGNED_EN
    .op_signed   (op_sg),
`endif
    .busy        (busy_w[1]),
    .done        (done_w[1]),
    .quotient    (q_w[1]),
    .remainder   (r_w[1]),
    .div_by_zero (z_w[1])
  );

  // Reference: plain integer division semantics.
  function automatic void ref_div(input logic [31:0] a, input logic [31:0] b, input logic s,
                                  output logic [31:0] q, output logic [31:0] r, output logic z);
    longint sa, sb;
    if (b == 32'd0) begin
      q = 32'hFFFF_FFFF;
      r = a;
      z = 1'b1;
    end else begin
      z = 1'b0;
      if (s) begin
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        q  = 32'(sa / sb);
        r  = 32'(sa % sb);
      end else begin
        q = a / b;
        r = a % b;
      end
    end
  endfunction

  // Issue one divide and watch both DUTs for a fixed 40-cycle window.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic s,
                        input int pulse_at, input logic [31:0] pa, input logic [31:0] pb);
    ref_div(a, b, s, e_q, e_r, e_z);
    e_lat[0] = (b == 32'd0) ? 1 : 33;
    e_lat[1] = (b == 32'd0) ? 1 : 9;
    dividend = a;
    divisor  = b;
`ifdef DIV_SIGNED_EN
    op_sg = s;
`endif
    start = 1'b1;
    @(posedge clk); #1;
    start    = 1'b0;
    dividend = $urandom;
    divisor  = $urandom;
    for (int d = 0; d < 2; d++) begin
      o_lat[d] = -1;
      o_dn[d]  = 0;
      o_bb[d]  = 1'b0;
    end
    for (int c = 1; c <= 40; c++) begin
      if (c == pulse_at) begin
        start    = 1'b1;
        dividend = pa;
        divisor  = pb;
      end
      @(posedge clk); #1;
      start = 1'b0;
      for (int d = 0; d < 2; d++) begin
        if (done_w[d]) begin
          o_dn[d]++;
          if (o_lat[d] < 0) begin
            o_lat[d] = c;
            o_q[d]   = q_w[d];
            o_r[d]   = r_w[d];
            o_z[d]   = z_w[d];
          end
        end else if (o_lat[d] < 0 && !busy_w[d]) begin
          o_bb[d] = 1'b1;
        end
      end
    end
    for (int d = 0; d < 2; d++) begin
      o_hq[d]       = q_w[d];
      o_hr[d]       = r_w[d];
      o_busy_end[d] = busy_w[d];
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; dividend = '0; divisor = '0;
`ifdef DIV_SIGNED_EN
    op_sg = 1'b0;
`endif
    repeat (2) @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      checks++; if (busy_w[d] !== 1'b0) begin errors++; $display("FAIL reset.busy dut%0d got=%b exp=0", d, busy_w[d]); end
      checks++; if (done_w[d] !== 1'b0) begin errors++; $display("FAIL reset.done dut%0d got=%b exp=0", d, done_w[d]); end
      checks++; if (q_w[d] !== 32'd0) begin errors++; $display("FAIL reset.quotient dut%0d got=%h exp=0", d, q_w[d]); end
      checks++; if (r_w[d] !== 32'd0) begin errors++; $display("FAIL reset.remainder dut%0d got=%h exp=0", d, r_w[d]); end
      checks++; if (z_w[d] !== 1'b0) begin errors++; $display("FAIL reset.dbz dut%0d got=%b exp=0", d, z_w[d]); end
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    run_op(32'd100, 32'd7, 1'b0, 0, 32'd0, 32'd0);
    for (int d = 0; d < 2; d++) begin
      checks++; if (o_q[d] !== e_q) begin errors++; $display("FAIL basic.quotient dut%0d got=%h exp=%h", d, o_q[d], e_q); end
      checks++; if (o_r[d] !== e_r) begin errors++; $display("FAIL basic.remainder dut%0d got=%h exp=%h", d, o_r[d], e_r); end
      checks++; if (o_z[d] !== 1'b0) begin errors++; $display("FAIL basic.dbz dut%0d got=%b exp=0", d, o_z[d]); end
      checks++; if (o_lat[d] != e_lat[d]) begin errors++; $display("FAIL basic.latency dut%0d got=%0d exp=%0d", d, o_lat[d], e_lat[d]); end
      checks++; if (o_dn[d] != 1) begin errors++; $display("FAIL basic.done_pulses dut%0d got=%0d exp=1", d, o_dn[d]); end
      checks++; if (o_bb[d]) begin errors++; $display("FAIL basic.busy dut%0d got=low_before_done exp=high", d); end
      checks++; if (o_hq[d] !== e_q || o_hr[d] !== e_r) begin errors++; $display("FAIL basic.hold dut%0d got=%h/%h exp=%h/%h", d, o_hq[d], o_hr[d], e_q, e_r); end
      checks++; if (o_busy_end[d] !== 1'b0) begin errors++; $display("FAIL basic.idle dut%0d got=%b exp=0", d, o_busy_end[d]); end
    end
  endtask

  task automatic test_div_zero();
    run_op(32'hFFFF_FFFF, 32'd0, 1'b0, 0, 32'd0, 32'd0);
    for (int d = 0; d < 2; d++) begin
      checks++; if (o_q[d] !== 32'hFFFF_FFFF) begin errors++; $display("FAIL dz.quotient dut%0d got=%h exp=ffffffff", d, o_q[d]); end
      checks++; if (o_r[d] !== 32'hFFFF_FFFF) begin errors++; $display("FAIL dz.remainder dut%0d got=%h exp=ffffffff", d, o_r[d]); end
      checks++; if (o_z[d] !== 1'b1) begin errors++; $display("FAIL dz.dbz dut%0d got=%b exp=1", d, o_z[d]); end
      checks++; if (o_lat[d] != 1) begin errors++; $display("FAIL dz.latency dut%0d got=%0d exp=1", d, o_lat[d]); end
      checks++; if (o_dn[d] != 1) begin errors++; $display("FAIL dz.done_pulses dut%0d got=%0d exp=1", d, o_dn[d]); end
    end
  endtask

  task automatic test_steps4();
    run_op(32'h8000_0000, 32'd3, 1'b0, 0, 32'd0, 32'd0);
    for (int d = 0; d < 2; d++) begin
      checks++; if (o_q[d] !== 32'h2AAA_AAAA) begin errors++; $display("FAIL msb.quotient dut%0d got=%h exp=2aaaaaaa", d, o_q[d]); end
      checks++; if (o_r[d] !== 32'd2) begin errors++; $display("FAIL msb.remainder dut%0d got=%h exp=2", d, o_r[d]); end
      checks++; if (o_lat[d] != e_lat[d]) begin errors++; $display("FAIL msb.latency dut%0d got=%0d exp=%0d", d, o_lat[d], e_lat[d]); end
    end
  endtask

  task automatic test_ignore_start();
    run_op(32'd100, 32'd7, 1'b0, 5, 32'd50, 32'd5);
    for (int d = 0; d < 2; d++) begin
      checks++; if (o_q[d] !== 32'd14 || o_r[d] !== 32'd2) begin errors++; $display("FAIL ignore.result dut%0d got=%h/%h exp=e/2", d, o_q[d], o_r[d]); end
      checks++; if (o_dn[d] != 1) begin errors++; $display("FAIL ignore.done_pulses dut%0d got=%0d exp=1", d, o_dn[d]); end
      checks++; if (o_busy_end[d] !== 1'b0) begin errors++; $display("FAIL ignore.idle dut%0d got=%b exp=0", d, o_busy_end[d]); end
    end
    run_op(32'd50, 32'd5, 1'b0, 0, 32'd0, 32'd0);
    for (int d = 0; d < 2; d++) begin
      checks++; if (o_q[d] !== e_q || o_r[d] !== e_r) begin errors++; $display("FAIL ignore.second dut%0d got=%h/%h exp=%h/%h", d, o_q[d], o_r[d], e_q, e_r); end
      checks++; if (o_lat[d] != e_lat[d]) begin errors++; $display("FAIL ignore.second_latency dut%0d got=%0d exp=%0d", d, o_lat[d], e_lat[d]); end
    end
  endtask

  task automatic test_reset_mid();
    int dn_seen[2];
    bit busy_seen[2];
    dividend = 32'd100; divisor = 32'd7; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    for (int d = 0; d < 2; d++) begin
      checks++; if (q_w[d] !== 32'd0 || r_w[d] !== 32'd0 || z_w[d] !== 1'b0) begin errors++; $display("FAIL rstmid.outputs dut%0d got=%h/%h/%b exp=0/0/0", d, q_w[d], r_w[d], z_w[d]); end
      checks++; if (busy_w[d] !== 1'b0) begin errors++; $display("FAIL rstmid.busy dut%0d got=%b exp=0", d, busy_w[d]); end
      dn_seen[d] = 0; busy_seen[d] = 1'b0;
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk); #1;
      for (int d = 0; d < 2; d++) begin
        if (done_w[d]) dn_seen[d]++;
        if (busy_w[d]) busy_seen[d] = 1'b1;
      end
    end
    for (int d = 0; d < 2; d++) begin
      checks++; if (dn_seen[d] != 0) begin errors++; $display("FAIL rstmid.no_done dut%0d got=%0d exp=0", d, dn_seen[d]); end
      checks++; if (busy_seen[d]) begin errors++; $display("FAIL rstmid.stays_idle dut%0d got=busy exp=idle", d); end
      checks++; if (q_w[d] !== 32'd0 || r_w[d] !== 32'd0) begin errors++; $display("FAIL rstmid.held_zero dut%0d got=%h/%h exp=0/0", d, q_w[d], r_w[d]); end
    end
    run_op(32'd9, 32'd3, 1'b0, 0, 32'd0, 32'd0);
    for (int d = 0; d < 2; d++) begin
      checks++; if (o_q[d] !== 32'd3 || o_r[d] !== 32'd0) begin errors++; $display("FAIL rstmid.after dut%0d got=%h/%h exp=3/0", d, o_q[d], o_r[d]); end
    end
  endtask

  task automatic test_random(input logic s, input int n);
    logic [31:0] a, b;
    for (int i = 0; i < n; i++) begin
      a = $urandom;
      case ($urandom_range(0, 5))
        0:       b = 32'd0;
        1:       b = 32'd1;
        2:       b = $urandom_range(1, 255);
        3:       b = a | $urandom;
        4:       b = $urandom >> $urandom_range(0, 31);
        default: b = $urandom;
      endcase
      if ($urandom_range(0, 3) == 0) a = a >> $urandom_range(0, 31);
      run_op(a, b, s, 0, 32'd0, 32'd0);
      for (int d = 0; d < 2; d++) begin
        checks++; if (o_q[d] !== e_q || o_r[d] !== e_r || o_z[d] !== e_z) begin errors++; $display("FAIL rand.result s=%0b dut%0d %h/%h got=%h/%h/%b exp=%h/%h/%b", s, d, a, b, o_q[d], o_r[d], o_z[d], e_q, e_r, e_z); end
        checks++; if (o_lat[d] != e_lat[d] || o_dn[d] != 1) begin errors++; $display("FAIL rand.timing s=%0b dut%0d got=lat%0d/pulses%0d exp=lat%0d/pulses1", s, d, o_lat[d], o_dn[d], e_lat[d]); end
      end
    end
  endtask

`ifdef DIV_SIGNED_EN
  task automatic test_signed();
    run_op(-32'sd7, 32'd2, 1'b1, 0, 32'd0, 32'd0);
    for (int d = 0; d < 2; d++) begin
      checks++; if (o_q[d] !== 32'hFFFF_FFFD || o_r[d] !== 32'hFFFF_FFFF) begin errors++; $display("FAIL signed.neg7by2 dut%0d got=%h/%h exp=fffffffd/ffffffff", d, o_q[d], o_r[d]); end
    end
    run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 0, 32'd0, 32'd0);
    for (int d = 0; d < 2; d++) begin
      checks++; if (o_q[d] !== 32'h8000_0000 || o_r[d] !== 32'd0) begin errors++; $display("FAIL signed.min_by_m1 dut%0d got=%h/%h exp=80000000/0", d, o_q[d], o_r[d]); end
    end
    run_op(-32'sd5, 32'd0, 1'b1, 0, 32'd0, 32'd0);
    for (int d = 0; d < 2; d++) begin
      checks++; if (o_q[d] !== 32'hFFFF_FFFF || o_r[d] !== 32'hFFFF_FFFB || o_z[d] !== 1'b1) begin errors++; $display("FAIL signed.div0 dut%0d got=%h/%h/%b exp=ffffffff/fffffffb/1", d, o_q[d], o_r[d], o_z[d]); end
    end
    test_random(1'b1, 15);
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_div_zero();
    test_steps4();
    test_ignore_start();
    test_reset_mid();
    test_random(1'b0, 25);
`ifdef DIV_SIGNED_EN
    test_signed();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
